gb10_cpu_cluster_sched: RTL and testbench

Parametrised successor to the synthetic CPU cluster model. Adds a valid/ready task-dispatch port, per-core IDLE/RUN/DONE sequencing, a round-robin retire port, a global halt/drain state machine, and per-core enable masking. Sits between the workload generator and the performance-monitoring fabric in the GB10 CPU subsystem.

---
 rtl/gb10_cpu_cluster_sched.sv | 268 ++++++++++++++++++++++++++
 tb/tb_gb10_cpu_cluster_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb10_cpu_cluster_sched.sv
// GB10 CPU cluster scheduler: valid/ready task dispatch onto CORE_COUNT synthetic cores,
// round-robin retire, halt/drain control. Define GB10_CPU_CLUSTER_SCHED_PERF_EN for perf counters.
module gb10_cpu_cluster_sched #(
    parameter int CORE_COUNT = 72,
    parameter int XLEN       = 64,
    parameter int LEN_W      = 8,
    parameter int CIDX_W     = $clog2(CORE_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  task_valid_i,
    output logic                  task_ready_o,
    input  logic [XLEN-1:0]       task_pc_i,
    input  logic [XLEN-1:0]       task_data_i,
    input  logic [LEN_W-1:0]      task_len_i,
    input  logic [CORE_COUNT-1:0] core_mask_i,
    output logic                  retire_valid_o,
    input  logic                  retire_ready_i,
    output logic [CIDX_W-1:0]     retire_core_o,
    output logic [XLEN-1:0]       retire_pc_o,
    output logic [XLEN-1:0]       retire_result_o,
    output logic [CORE_COUNT-1:0] busy_o,
    input  logic                  halt_req_i,
    output logic                  halted_o,
    output logic [63:0]           perf_cycles_o,
    output logic [63:0]           perf_retired_o,
    output logic [63:0]           perf_active_o
);

    typedef enum logic [1:0] {
        CORE_IDLE = 2'd0,
        CORE_RUN  = 2'd1,
        CORE_DONE = 2'd2
    } core_state_e;

    typedef enum logic [1:0] {
        GBL_RUN    = 2'd0,
        GBL_DRAIN  = 2'd1,
        GBL_HALTED = 2'd2
    } gbl_state_e;

    localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    function automatic logic [CIDX_W-1:0] wrap_idx(input logic [CIDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= CORE_COUNT) ? CIDX_W'(sum - CORE_COUNT) : CIDX_W'(sum);
    endfunction

    // Scanning from farthest to nearest lets the nearest requester at/after ptr win without priority ifs.
    function automatic logic [CIDX_W:0] rr_pick(input logic [CORE_COUNT-1:0] req,
                                                 input logic [CIDX_W-1:0]     ptr);
        logic              found;
        logic [CIDX_W-1:0] idx;
        logic [CIDX_W-1:0] cand;
        found = 1'b0;
        idx   = {CIDX_W{1'b0}};
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            cand  = wrap_idx(ptr, i);
            found = found | req[cand];
            idx   = req[cand] ? cand : idx;
        end
        return {found, idx};
    endfunction

    core_state_e       cst_r [CORE_COUNT];
    logic [XLEN-1:0]   pc_r  [CORE_COUNT];
    logic [XLEN-1:0]   acc_r [CORE_COUNT];
    logic [XLEN-1:0]   opd_r [CORE_COUNT];
    logic [LEN_W-1:0]  rem_r [CORE_COUNT];

    gbl_state_e        gst_r;
    logic [CIDX_W-1:0] disp_ptr_r;
    logic [CIDX_W-1:0] ret_ptr_r;
    logic              lock_vld_r;
    logic [CIDX_W-1:0] lock_idx_r;

    logic [CORE_COUNT-1:0] idle_s;
    logic [CORE_COUNT-1:0] done_s;
    logic                  all_idle_s;
    logic [CIDX_W:0]       disp_pick_s;
    logic [CIDX_W:0]       ret_pick_s;
    logic [CIDX_W-1:0]     disp_idx_s;
    logic                  task_ready_s;
    logic                  disp_fire_s;
    logic                  ret_valid_s;
    logic [CIDX_W-1:0]     ret_idx_s;
    logic                  ret_fire_s;

    // Per-core state decode.
    always_comb begin
        idle_s = {CORE_COUNT{1'b0}};
        done_s = {CORE_COUNT{1'b0}};
        for (int c = 0; c < CORE_COUNT; c++) begin
            idle_s[c] = (cst_r[c] == CORE_IDLE);
            done_s[c] = (cst_r[c] == CORE_DONE);
        end
    end

    assign all_idle_s   = &idle_s;
    assign disp_pick_s  = rr_pick(idle_s & core_mask_i, disp_ptr_r);
    assign disp_idx_s   = disp_pick_s[CIDX_W-1:0];
    assign task_ready_s = (gst_r == GBL_RUN) && disp_pick_s[CIDX_W];
    assign disp_fire_s  = task_valid_i && task_ready_s;

    // A held grant stays locked so a newly DONE core nearer the pointer cannot steal it.
    assign ret_pick_s   = rr_pick(done_s, ret_ptr_r);
    assign ret_valid_s  = lock_vld_r | ret_pick_s[CIDX_W];
    assign ret_idx_s    = lock_vld_r ? lock_idx_r : ret_pick_s[CIDX_W-1:0];
    assign ret_fire_s   = ret_valid_s && retire_ready_i;

    // Retire port and status outputs, decoded from registered state.
    always_comb begin
        task_ready_o   = task_ready_s;
        retire_valid_o = ret_valid_s;
        busy_o         = ~idle_s;
        halted_o       = (gst_r == GBL_HALTED);
        if (ret_valid_s) begin
            retire_core_o   = ret_idx_s;
            retire_pc_o     = pc_r[ret_idx_s];
            retire_result_o = acc_r[ret_idx_s];
        end else begin
            retire_core_o   = {CIDX_W{1'b0}};
            retire_pc_o     = {XLEN{1'b0}};
            retire_result_o = {XLEN{1'b0}};
        end
    end

    // Per-core IDLE/RUN/DONE sequencing and accumulate datapath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CORE_COUNT; c++) begin
                cst_r[c] <= CORE_IDLE;
                pc_r[c]  <= {XLEN{1'b0}};
                acc_r[c] <= {XLEN{1'b0}};
                opd_r[c] <= {XLEN{1'b0}};
                rem_r[c] <= {LEN_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < CORE_COUNT; c++) begin
                case (cst_r[c])
                    CORE_IDLE: begin
                        if (disp_fire_s && (disp_idx_s == CIDX_W'(c))) begin
                            cst_r[c] <= CORE_RUN;
                            pc_r[c]  <= task_pc_i;
                            acc_r[c] <= {XLEN{1'b0}};
                            opd_r[c] <= task_data_i;
                            rem_r[c] <= (task_len_i == {LEN_W{1'b0}}) ? LEN_ONE : task_len_i;
                        end else begin
                            cst_r[c] <= CORE_IDLE;
                        end
                    end
                    CORE_RUN: begin
                        pc_r[c]  <= pc_r[c] + PC_STEP;
                        acc_r[c] <= acc_r[c] + opd_r[c];
                        rem_r[c] <= rem_r[c] - LEN_ONE;
                        if (rem_r[c] == LEN_ONE) begin
                            cst_r[c] <= CORE_DONE;
                        end else begin
                            cst_r[c] <= CORE_RUN;
                        end
                    end
                    CORE_DONE: begin
                        if (ret_fire_s && (ret_idx_s == CIDX_W'(c))) begin
                            cst_r[c] <= CORE_IDLE;
                        end else begin
                            cst_r[c] <= CORE_DONE;
                        end
                    end
                    default: begin
                        cst_r[c] <= CORE_IDLE;
                    end
                endcase
            end
        end
    end

    // Dispatch/retire pointers and retire grant lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disp_ptr_r <= {CIDX_W{1'b0}};
            ret_ptr_r  <= {CIDX_W{1'b0}};
            lock_vld_r <= 1'b0;
            lock_idx_r <= {CIDX_W{1'b0}};
        end else begin
            if (disp_fire_s) begin
                disp_ptr_r <= wrap_idx(disp_idx_s, 1);
            end
            if (ret_fire_s) begin
                ret_ptr_r <= wrap_idx(ret_idx_s, 1);
            end
            lock_vld_r <= ret_valid_s && !retire_ready_i;
            lock_idx_r <= ret_idx_s;
        end
    end

    // Global RUN/DRAIN/HALTED sequencing; a dropped halt request always returns to RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gst_r <= GBL_RUN;
        end else begin
            case (gst_r)
                GBL_RUN: begin
                    if (halt_req_i) begin
                        gst_r <= GBL_DRAIN;
                    end
                end
                GBL_DRAIN: begin
                    if (!halt_req_i) begin
                        gst_r <= GBL_RUN;
                    end else if (all_idle_s) begin
                        gst_r <= GBL_HALTED;
                    end
                end
                GBL_HALTED: begin
                    if (!halt_req_i) begin
                        gst_r <= GBL_RUN;
                    end
                end
                default: begin
                    gst_r <= GBL_RUN;
                end
            endcase
        end
    end

`ifdef GB10_CPU_CLUSTER_SCHED_PERF_EN
    logic [63:0] perf_cycles_r;
    logic [63:0] perf_retired_r;
    logic [63:0] perf_active_r;
    logic [63:0] run_cnt_s;

    // Number of cores in RUN this cycle.
    always_comb begin
        run_cnt_s = 64'd0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            run_cnt_s = run_cnt_s + {63'd0, (cst_r[c] == CORE_RUN)};
        end
    end

    // Wrapping performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles_r  <= 64'd0;
            perf_retired_r <= 64'd0;
            perf_active_r  <= 64'd0;
        end else begin
            if (gst_r != GBL_HALTED) begin
                perf_cycles_r <= perf_cycles_r + 64'd1;
            end
            if (ret_fire_s) begin
                perf_retired_r <= perf_retired_r + 64'd1;
            end
            perf_active_r <= perf_active_r + run_cnt_s;
        end
    end

    assign perf_cycles_o  = perf_cycles_r;
    assign perf_retired_o = perf_retired_r;
    assign perf_active_o  = perf_active_r;
`else
    assign perf_cycles_o  = 64'd0;
    assign perf_retired_o = 64'd0;
    assign perf_active_o  = 64'd0;
`endif

endmodule

// File: tb/tb_gb10_cpu_cluster_sched.sv
// Self-checking bench for gb10_cpu_cluster_sched (CORE_COUNT=4): task-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_gb10_cpu_cluster_sched;
    localparam int N  = 4;
    localparam int XL = 64;
    localparam int LW = 8;
    localparam int CW = 2;

`ifdef GB10_CPU_CLUSTER_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          task_valid_i;
    logic          task_ready_o;
    logic [XL-1:0] task_pc_i;
    logic [XL-1:0] task_data_i;
    logic [LW-1:0] task_len_i;
    logic [N-1:0]  core_mask_i;
    logic          retire_valid_o;
    logic          retire_ready_i;
    logic [CW-1:0] retire_core_o;
    logic [XL-1:0] retire_pc_o;
    logic [XL-1:0] retire_result_o;
    logic [N-1:0]  busy_o;
    logic          halt_req_i;
    logic          halted_o;
    logic [63:0]   perf_cycles_o;
    logic [63:0]   perf_retired_o;
    logic [63:0]   perf_active_o;

    gb10_cpu_cluster_sched #(.CORE_COUNT(N), .XLEN(XL), .LEN_W(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
        .task_pc_i(task_pc_i), .task_data_i(task_data_i), .task_len_i(task_len_i),
        .core_mask_i(core_mask_i),
        .retire_valid_o(retire_valid_o), .retire_ready_i(retire_ready_i),
        .retire_core_o(retire_core_o), .retire_pc_o(retire_pc_o),
        .retire_result_o(retire_result_o), .busy_o(busy_o),
        .halt_req_i(halt_req_i), .halted_o(halted_o),
        .perf_cycles_o(perf_cycles_o), .perf_retired_o(perf_retired_o),
        .perf_active_o(perf_active_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Task-level model: each busy core remembers when it finishes and its closed-form result.
    bit          m_busy    [N];
    int          m_done_at [N];
    logic [63:0] m_pc0     [N];
    logic [63:0] m_data    [N];
    int          m_len     [N];
    int          m_n, m_dptr, m_rptr, m_phase, m_lock_idx;
    bit          m_lock;
    logic [63:0] m_cyc, m_ret, m_act;

    bit          ex_ready, ex_rvalid, ex_halted, ex_all_idle;
    int          ex_dcore, ex_rcore, ex_nrun;
    logic [63:0] ex_rpc, ex_rres;
    logic [N-1:0] ex_busy;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_busy[c] = 1'b0; m_done_at[c] = 0; m_pc0[c] = 64'd0; m_data[c] = 64'd0; m_len[c] = 0;
        end
        m_n = 0; m_dptr = 0; m_rptr = 0; m_phase = 0; m_lock = 1'b0; m_lock_idx = 0;
        m_cyc = 64'd0; m_ret = 64'd0; m_act = 64'd0;
    endtask

    task automatic model_eval();
        ex_busy = '0; ex_nrun = 0; ex_all_idle = 1'b1;
        for (int c = 0; c < N; c++) begin
            if (m_busy[c]) begin
                ex_busy[c] = 1'b1;
                ex_all_idle = 1'b0;
                if (m_n < m_done_at[c]) ex_nrun++;
            end
        end
        ex_ready = 1'b0; ex_dcore = 0;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_dptr + k) % N;
                if (!ex_ready && !m_busy[c] && core_mask_i[c]) begin ex_ready = 1'b1; ex_dcore = c; end
            end
        end
        ex_rvalid = 1'b0; ex_rcore = 0;
        if (m_lock) begin
            ex_rvalid = 1'b1; ex_rcore = m_lock_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c = (m_rptr + k) % N;
                if (!ex_rvalid && m_busy[c] && m_n >= m_done_at[c]) begin ex_rvalid = 1'b1; ex_rcore = c; end
            end
        end
        ex_rpc    = m_pc0[ex_rcore] + 64'(4 * m_len[ex_rcore]);
        ex_rres   = m_data[ex_rcore] * 64'(m_len[ex_rcore]);
        ex_halted = (m_phase == 2);
    endtask

    task automatic model_step();
        bit hs, dp;
        int rc, dc, len;
        model_eval();
        hs = ex_rvalid && retire_ready_i; rc = ex_rcore;
        dp = task_valid_i && ex_ready;    dc = ex_dcore;
        if (m_phase != 2) m_cyc = m_cyc + 64'd1;
        if (hs) m_ret = m_ret + 64'd1;
        m_act = m_act + 64'(ex_nrun);
        m_lock = ex_rvalid && !retire_ready_i; m_lock_idx = ex_rcore;
        m_n++;
        if (hs) begin m_busy[rc] = 1'b0; m_rptr = (rc + 1) % N; end
        if (dp) begin
            len = (task_len_i == 8'd0) ? 1 : int'(task_len_i);
            m_busy[dc] = 1'b1; m_done_at[dc] = m_n + len; m_len[dc] = len;
            m_pc0[dc] = task_pc_i; m_data[dc] = task_data_i; m_dptr = (dc + 1) % N;
        end
        case (m_phase)
            0: if (halt_req_i) m_phase = 1;
            1: if (!halt_req_i) m_phase = 0; else if (ex_all_idle) m_phase = 2;
            2: if (!halt_req_i) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    // Compare process: all outputs against the model, just after every active edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            model_eval();
            chk("m_ready",   64'(task_ready_o),   64'(ex_ready));
            chk("m_rvalid",  64'(retire_valid_o), 64'(ex_rvalid));
            if (ex_rvalid) begin
                chk("m_rcore",   64'(retire_core_o), 64'(ex_rcore));
                chk("m_rpc",     retire_pc_o,        ex_rpc);
                chk("m_rresult", retire_result_o,    ex_rres);
            end
            chk("m_busy",    64'(busy_o),   64'(ex_busy));
            chk("m_halted",  64'(halted_o), 64'(ex_halted));
            chk("m_pcycles", perf_cycles_o,  PERF ? m_cyc : 64'd0);
            chk("m_pretire", perf_retired_o, PERF ? m_ret : 64'd0);
            chk("m_pactive", perf_active_o,  PERF ? m_act : 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        task_valid_i = 1'b0; task_pc_i = 64'd0; task_data_i = 64'd0; task_len_i = 8'd0;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [63:0] data, input logic [7:0] len);
        task_valid_i = 1'b1; task_pc_i = pc; task_data_i = data; task_len_i = len;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; idle_inputs(); halt_req_i = 1'b0; retire_ready_i = 1'b1; core_mask_i = 4'hF;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    int k;
    int exp_busy;
    bit saw;

    initial begin
        rst_ni = 1'b0; idle_inputs(); halt_req_i = 1'b0; retire_ready_i = 1'b1; core_mask_i = 4'hF;

        // Reset values.
        @(negedge clk_i);
        chk("rst_ready",   64'(task_ready_o), 64'd1);
        chk("rst_rvalid",  64'(retire_valid_o), 64'd0);
        chk("rst_rcore",   64'(retire_core_o), 64'd0);
        chk("rst_rpc",     retire_pc_o, 64'd0);
        chk("rst_rresult", retire_result_o, 64'd0);
        chk("rst_busy",    64'(busy_o), 64'd0);
        chk("rst_halted",  64'(halted_o), 64'd0);
        chk("rst_pcycles", perf_cycles_o, 64'd0);
        core_mask_i = 4'h0;
        #1 chk("rst_ready_nomask", 64'(task_ready_o), 64'd0);
        core_mask_i = 4'hF;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single task.
        @(negedge clk_i);
        offer(64'h1000, 64'd3, 8'd5);
        @(negedge clk_i);
        idle_inputs();
        chk("s1_busy", 64'(busy_o), 64'h1);
        k = 1;
        while (!retire_valid_o && k < 40) begin @(negedge clk_i); k++; end
        chk("s1_latency", 64'(k), 64'd6);
        chk("s1_core",    64'(retire_core_o), 64'd0);
        chk("s1_pc",      retire_pc_o, 64'h1014);
        chk("s1_result",  retire_result_o, 64'd15);
        @(negedge clk_i);
        chk("s1_rvalid_drop", 64'(retire_valid_o), 64'd0);
        chk("s1_pretired", perf_retired_o, PERF ? 64'd1 : 64'd0);
        chk("s1_pactive",  perf_active_o,  PERF ? 64'd5 : 64'd0);

        // Length 0 behaves as length 1.
        offer(64'h2000, 64'd7, 8'd0);
        @(negedge clk_i);
        idle_inputs();
        k = 1;
        while (!retire_valid_o && k < 40) begin @(negedge clk_i); k++; end
        chk("s2_latency", 64'(k), 64'd2);
        chk("s2_core",    64'(retire_core_o), 64'd1);
        chk("s2_pc",      retire_pc_o, 64'h2004);
        chk("s2_result",  retire_result_o, 64'd7);
        @(negedge clk_i);

        // Full cluster with retire backpressure.
        do_reset();
        retire_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s3_ready%0d", i), 64'(task_ready_o), (i < 4) ? 64'd1 : 64'd0);
            offer(64'h100 * 64'(i + 1), 64'(i + 1), 8'd20);
            @(negedge clk_i);
            exp_busy = (i < 4) ? ((1 << (i + 1)) - 1) : 15;
            chk($sformatf("s3_busy%0d", i), 64'(busy_o), 64'(exp_busy));
        end
        idle_inputs();
        k = 0;
        while (!retire_valid_o && k < 40) begin @(negedge clk_i); k++; end
        chk("s3_first_valid", 64'(retire_valid_o), 64'd1);
        for (int j = 0; j < 6; j++) begin
            chk("s3_hold_valid", 64'(retire_valid_o), 64'd1);
            chk("s3_hold_core",  64'(retire_core_o), 64'd0);
            @(negedge clk_i);
        end
        retire_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("s3_order%0d", j), 64'(retire_core_o), 64'(j));
            chk("s3_order_valid", 64'(retire_valid_o), 64'd1);
            @(negedge clk_i);
        end
        chk("s3_empty", 64'(busy_o), 64'd0);

        // Core masking; clearing a mask bit leaves the running task alone.
        do_reset();
        core_mask_i = 4'b1010;
        offer(64'h3000, 64'd5, 8'd10);
        @(negedge clk_i);
        chk("s4_busy_a", 64'(busy_o), 64'h2);
        offer(64'h4000, 64'd2, 8'd3);
        @(negedge clk_i);
        chk("s4_busy_b", 64'(busy_o), 64'hA);
        idle_inputs();
        core_mask_i = 4'b1000;
        #1 chk("s4_ready_masked", 64'(task_ready_o), 64'd0);
        k = 0;
        while (!(retire_valid_o && retire_core_o == 2'd1) && k < 40) begin @(negedge clk_i); k++; end
        chk("s4_core1_valid",  64'(retire_valid_o), 64'd1);
        chk("s4_core1_pc",     retire_pc_o, 64'h3028);
        chk("s4_core1_result", retire_result_o, 64'd50);
        @(negedge clk_i);

        // Halt / drain.
        do_reset();
        offer(64'h5000, 64'd1, 8'd8);
        @(negedge clk_i);
        offer(64'h6000, 64'd2, 8'd10);
        @(negedge clk_i);
        offer(64'h7000, 64'd3, 8'd12);
        @(negedge clk_i);
        idle_inputs();
        halt_req_i = 1'b1;
        @(negedge clk_i);
        chk("s5_ready_drain", 64'(task_ready_o), 64'd0);
        chk("s5_not_halted",  64'(halted_o), 64'd0);
        k = 4;
        while (!halted_o && k < 60) begin @(negedge clk_i); k++; end
        chk("s5_halt_cycle", 64'(k), 64'd17);
        chk("s5_busy",       64'(busy_o), 64'd0);
        chk("s5_pcycles",    perf_cycles_o,  PERF ? 64'd17 : 64'd0);
        chk("s5_pretired",   perf_retired_o, PERF ? 64'd3 : 64'd0);
        chk("s5_pactive",    perf_active_o,  PERF ? 64'd30 : 64'd0);
        repeat (5) @(negedge clk_i);
        chk("s5_pcycles_frozen", perf_cycles_o, PERF ? 64'd17 : 64'd0);
        halt_req_i = 1'b0;
        @(negedge clk_i);
        chk("s5_ready_resume", 64'(task_ready_o), 64'd1);
        chk("s5_unhalted",     64'(halted_o), 64'd0);

        // Asynchronous reset with two cores running.
        do_reset();
        offer(64'h8000, 64'd9, 8'd30);
        @(negedge clk_i);
        offer(64'h9000, 64'd9, 8'd30);
        @(negedge clk_i);
        idle_inputs();
        repeat (3) @(negedge clk_i);
        chk("s6_busy_before", 64'(busy_o), 64'h3);
        rst_ni = 1'b0;
        #1;
        chk("s6_busy",    64'(busy_o), 64'd0);
        chk("s6_rvalid",  64'(retire_valid_o), 64'd0);
        chk("s6_ready",   64'(task_ready_o), 64'd1);
        chk("s6_pcycles", perf_cycles_o, 64'd0);
        chk("s6_pactive", perf_active_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (retire_valid_o) saw = 1'b1;
        end
        chk("s6_no_retire", 64'(saw), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
